// File: rtl/cm0_rst_ctrl.sv
// Reset request sequencer: merges reset triggers into staggered SYSRSTREQ/CORERSTREQ
// with a minimum hold and a sticky cause register. Lockup trigger gated by CM0_RST_CTRL_LOCKUP_EN.
module cm0_rst_ctrl #(
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned STAGGER_CYCLES = 3,
  parameter int unsigned CW             = 4
) (
  input  logic       CLK,
  input  logic       RSTINn,
  input  logic       SYSRESETREQ,
  input  logic       WDOGRESETREQ,
  input  logic       LOCKUP,
  input  logic       LOCKUPRESET,
  input  logic       RSTSTATCLR,
  output logic       SYSRSTREQ,
  output logic       CORERSTREQ,
  output logic       RSTBUSY,
  output logic [2:0] RSTSTAT
);

  localparam int unsigned CNT_MAX = (32'd1 << CW) - 32'd1;
  localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYCLES - 32'd1);
  localparam logic [CW-1:0] STAGGER_LOAD = CW'(STAGGER_CYCLES - 32'd1);

  // Elaboration-time legality of the configuration
  if (CW < 1 || CW > 31) begin : g_bad_cw
    $error("cm0_rst_ctrl: CW must be in 1..31");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_MAX) begin : g_bad_hold
    $error("cm0_rst_ctrl: HOLD_CYCLES must be in 1..2^CW-1");
  end
  if (STAGGER_CYCLES < 1 || STAGGER_CYCLES > CNT_MAX) begin : g_bad_stagger
    $error("cm0_rst_ctrl: STAGGER_CYCLES must be in 1..2^CW-1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sys_q, sys_d;
  logic          core_q, core_d;
  logic          busy_q, busy_d;
  logic [2:0]    stat_q, stat_d;
  logic          lock_trig;
  logic          trig;

`ifdef CM0_RST_CTRL_LOCKUP_EN
  assign lock_trig = LOCKUP & LOCKUPRESET;
`else
  logic unused_lock;
  assign unused_lock = LOCKUP ^ LOCKUPRESET;
  assign lock_trig   = 1'b0;
`endif

  assign trig = SYSRESETREQ | WDOGRESETREQ | lock_trig;

  // Sticky cause: a coincident set beats the clear
  assign stat_d = (RSTSTATCLR ? 3'b000 : stat_q) | {lock_trig, WDOGRESETREQ, SYSRESETREQ};

  // Sequencer next-state and registered-output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sys_d   = sys_q;
    core_d  = core_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_ASSERT;
          cnt_d   = HOLD_LOAD;
          sys_d   = 1'b1;
          core_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (cnt_q == '0) begin
          if (!trig) begin
            state_d = ST_RELEASE;
            cnt_d   = STAGGER_LOAD;
            sys_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RELEASE: begin
        if (trig) begin
          state_d = ST_ASSERT;
          cnt_d   = HOLD_LOAD;
          sys_d   = 1'b1;
          core_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
          core_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        if (trig) begin
          state_d = ST_ASSERT;
          cnt_d   = HOLD_LOAD;
          sys_d   = 1'b1;
          core_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sys_d   = 1'b0;
        core_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTINn) begin
    if (!RSTINn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sys_q   <= 1'b0;
      core_q  <= 1'b0;
      busy_q  <= 1'b0;
      stat_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sys_q   <= sys_d;
      core_q  <= core_d;
      busy_q  <= busy_d;
      stat_q  <= stat_d;
    end
  end

  assign SYSRSTREQ  = sys_q;
  assign CORERSTREQ = core_q;
  assign RSTBUSY    = busy_q;
  assign RSTSTAT    = stat_q;

endmodule
